// File: rtl/hs4_tx.sv
// Source side of a 4-phase req/ack CDC handshake with synchronized ack.
// Optional REQ abort timer enabled by defining HS4_TIMEOUT_EN.
module hs4_tx #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         res,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         req_out,
  output logic [N-1:0] data_out,
  input  logic         ack_in,
  output logic         busy,
  output logic         done,
  output logic         timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] REL  = 2'd2;

  if (SYNC_STAGES < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("hs4_tx: SYNC_STAGES and TIMEOUT_CYC must be >= 2");
  end

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   ack_s;
  logic                   accept;
  logic                   expire;
  logic                   aborted;

  always_ff @(posedge clk or posedge res) begin
    if (res) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], ack_in};
  end

  assign ack_s    = sync[SYNC_STAGES-1];
  assign busy     = (state != IDLE);
  // hold off a new word during the done cycle
  assign in_ready = (state == IDLE) && !ack_s && !done;
  assign accept   = in_valid && in_ready;

`ifdef HS4_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign expire = (state == REQ) && !ack_s &&
                  (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt     <= '0;
      aborted <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= expire;
      if (accept)
        cnt <= '0;
      else if (state == REQ && !ack_s)
        cnt <= cnt + 1'b1;
      if (expire)
        aborted <= 1'b1;
      else if (accept)
        aborted <= 1'b0;
    end
  end
`else
  assign expire  = 1'b0;
  assign aborted = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state    <= IDLE;
      req_out  <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            data_out <= in_data;
            req_out  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (ack_s || expire) begin
            req_out <= 1'b0;
            state   <= REL;
          end
        end
        REL: begin
          // an aborted word returns quietly
          if (!ack_s) begin
            state <= IDLE;
            done  <= !aborted;
          end
        end
        default: begin
          state   <= IDLE;
          req_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs4_tx.sv
// Scoreboard bench for hs4_tx: directed transfers, latency and reset cases.
// Monitor pops expected words on each req_out rise.
module tb_hs4_tx;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       req_out;
  logic [7:0] data_out;
  logic       ack_in;
  logic       busy;
  logic       done;
  logic       timeout;

  logic ack_man  = 1'b0;
  logic resp_en  = 1'b0;
  logic resp_ack = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;
  int last_done = -100;
  int acc_cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] held = '0;
  logic       req_prev = 1'b0;

  assign ack_in = resp_en ? resp_ack : ack_man;

  hs4_tx #(.N(8), .SYNC_STAGES(2), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .req_out(req_out), .data_out(data_out),
    .ack_in(ack_in), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // responder echoes req_out one cycle later
  always @(negedge clk) resp_ack <= req_out;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (res) begin
      req_prev = 1'b0;
    end else begin
      if (req_out && !req_prev) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_req", 32'(data_out), 32'hFFFF_FFFF);
        end else begin
          chk("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
        held = data_out;
      end else if (req_out && req_prev) begin
        chk("data_stable", 32'(data_out), 32'(held));
      end
      if (done) begin
        last_done = cyc_cnt;
        chk("done_vs_ready", 32'(in_ready), 32'd0);
      end
      req_prev = req_out;
    end
  end

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_bound", 32'd0, 32'd1);
    else acc_cyc = cyc_cnt;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    res = 1'b0;
    @(negedge clk);
    chk("rel_req", 32'(req_out), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_ready", 32'(in_ready), 32'd1);

    // single transfer with manual ack
    send(8'hA5);
    in_valid = 1'b0;
    chk("s_req_up", 32'(req_out), 32'd1);
    chk("s_busy", 32'(busy), 32'd1);
    chk("s_ready_lo", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    ack_man = 1'b1;
    @(negedge clk); chk("s_req_e1", 32'(req_out), 32'd1);
    @(negedge clk); chk("s_req_e2", 32'(req_out), 32'd1);
    @(negedge clk); chk("s_req_e3", 32'(req_out), 32'd0);
    chk("s_data_held", 32'(data_out), 32'hA5);
    chk("s_busy_rel", 32'(busy), 32'd1);
    ack_man = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("s_done_edge", 32'(done), 32'(k == 3));
    end
    chk("s_ready_done", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("s_done_off", 32'(done), 32'd0);
    chk("s_ready_after", 32'(in_ready), 32'd1);
    chk("s_busy_after", 32'(busy), 32'd0);

    // back-to-back with 1-cycle responder
    resp_en = 1'b1;
    send(8'h01);
    send(8'h02);
    chk("b2b_gap", 32'(acc_cyc - last_done), 32'd1);
    in_valid = 1'b0;
    wait_done();
    chk("b2b_data", 32'(data_out), 32'h02);
    @(negedge clk);
    resp_en = 1'b0;

    // stale ack at reset release
    res = 1'b1;
    ack_man = 1'b1;
    @(negedge clk);
    res = 1'b0;
    repeat (3) @(negedge clk);
    chk("stale_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h99;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stale_busy", 32'(busy), 32'd0);
      chk("stale_ready_hold", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    ack_man  = 1'b0;
    @(negedge clk); chk("stale_drop1", 32'(in_ready), 32'd0);
    @(negedge clk); chk("stale_drop2", 32'(in_ready), 32'd1);

    // reset in the middle of REQ
    send(8'h5A);
    in_valid = 1'b0;
    chk("mid_in_req", 32'(req_out), 32'd1);
    #2 res = 1'b1;
    #1;
    chk("mid_req_drop", 32'(req_out), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_data", 32'(data_out), 32'd0);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    resp_en = 1'b1;
    send(8'h3C);
    in_valid = 1'b0;
    wait_done();
    chk("mid_next_data", 32'(data_out), 32'h3C);
    @(negedge clk);
    resp_en = 1'b0;
    @(negedge clk);

    // no ack at all
    send(8'hE1);
    in_valid = 1'b0;
`ifdef HS4_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      chk("to_req_hold", 32'(req_out), 32'd1);
      chk("to_pulse_early", 32'(timeout), 32'd0);
      @(negedge clk);
    end
    chk("to_req_fall", 32'(req_out), 32'd0);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_no_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("to_pulse_end", 32'(timeout), 32'd0);
    chk("to_no_done2", 32'(done), 32'd0);
    chk("to_ready", 32'(in_ready), 32'd1);
`else
    begin
      int drops;
      drops = 0;
      for (int k = 0; k < 1000; k++) begin
        if (!req_out || timeout) drops++;
        @(negedge clk);
      end
      chk("hang_req_held", 32'(drops), 32'd0);
    end
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
